mem_addr_sel: RTL

- Registered, handshaked memory-address selector for the multicycle datapath; successor to the combinational address mux in front of the memory port.
- Picks the next memory address from PC, ALU result or ALUOut, or from one of three exception-vector addresses. Exception requests override the normal selection by priority.
- Checks alignment per access size, latches EPC on exception entry and holds the issued address stable until memory acknowledges.

---
 rtl/mem_addr_sel_if.sv | 36 +++
 rtl/mem_addr_sel.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_addr_sel_if.sv
// Request/response bundle between the datapath control and mem_addr_sel.
//   master : requester side (drives sources, size, exception flags, req, mem_ready)
//   slave  : mem_addr_sel side (drives addr, status pulses, epc)
interface mem_addr_sel_if #(
   parameter int unsigned WIDTH = 32
);
   logic [2:0]       seletor;
   logic [WIDTH-1:0] PC;
   logic [WIDTH-1:0] ULA_Result;
   logic [WIDTH-1:0] ULAOut;
   logic [1:0]       size;
   logic             exc_opcode;
   logic             exc_overflow;
   logic             exc_div0;
   logic             req;
   logic             req_ready;
   logic             mem_ready;
   logic [WIDTH-1:0] addr;
   logic             addr_valid;
   logic             misaligned;
   logic             bad_sel;
   logic [WIDTH-1:0] epc;
   logic             exc_taken;

   modport master (
      output seletor, PC, ULA_Result, ULAOut, size,
             exc_opcode, exc_overflow, exc_div0, req, mem_ready,
      input  req_ready, addr, addr_valid, misaligned, bad_sel, epc, exc_taken
   );

   modport slave (
      input  seletor, PC, ULA_Result, ULAOut, size,
             exc_opcode, exc_overflow, exc_div0, req, mem_ready,
      output req_ready, addr, addr_valid, misaligned, bad_sel, epc, exc_taken
   );
endinterface

// File: rtl/mem_addr_sel.sv
// Registered, handshaked memory-address selector for the multicycle datapath.
// Selects PC / ALU result / ALUOut or an exception vector, checks alignment,
// captures EPC on exception entry and holds the issued address until memory
// acknowledges it.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (aborts any access in flight)
//   bus     : mem_addr_sel_if.slave -- sources, size, exception flags,
//             req/req_ready, mem_ready, addr/addr_valid, status pulses, epc
module mem_addr_sel #(
   parameter int unsigned WIDTH           = 32,
   parameter int unsigned EXC_OPCODE_ADDR = 253,
   parameter int unsigned EXC_OVF_ADDR    = 254,
   parameter int unsigned EXC_DIV0_ADDR   = 255
) (
   input logic           clock,
   input logic           reset_n,
   mem_addr_sel_if.slave bus
);

   localparam logic [WIDTH-1:0] VEC_OPCODE = WIDTH'(EXC_OPCODE_ADDR);
   localparam logic [WIDTH-1:0] VEC_OVF    = WIDTH'(EXC_OVF_ADDR);
   localparam logic [WIDTH-1:0] VEC_DIV0   = WIDTH'(EXC_DIV0_ADDR);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t state;

   logic             exc_any_c;
   logic [WIDTH-1:0] exc_vec_c;
   logic [WIDTH-1:0] src_c;
   logic             src_is_vec_c;
   logic             sel_bad_c;
   logic             align_bad_c;

   // Request decode: exception vector by priority, normal source, validity checks.
   always_comb begin
      exc_any_c    = bus.exc_div0 | bus.exc_overflow | bus.exc_opcode;
      exc_vec_c    = VEC_OPCODE;
      src_c        = '0;
      src_is_vec_c = 1'b0;
      sel_bad_c    = (bus.size == 2'd3);
      align_bad_c  = 1'b0;

      if (bus.exc_div0) begin
         exc_vec_c = VEC_DIV0;
      end else if (bus.exc_overflow) begin
         exc_vec_c = VEC_OVF;
      end

      case (bus.seletor)
         3'd0: src_c = bus.PC;
         3'd1: src_c = bus.ULA_Result;
         3'd2: src_c = bus.ULAOut;
         3'd3: begin
            src_c        = VEC_OPCODE;
            src_is_vec_c = 1'b1;
         end
         3'd4: begin
            src_c        = VEC_OVF;
            src_is_vec_c = 1'b1;
         end
         3'd5: begin
            src_c        = VEC_DIV0;
            src_is_vec_c = 1'b1;
         end
         default: sel_bad_c = 1'b1;
      endcase

      // Vectors are byte addresses, so only data-path sources are alignment checked.
      if (!src_is_vec_c) begin
         case (bus.size)
            2'd1:    align_bad_c = src_c[0];
            2'd2:    align_bad_c = |src_c[1:0];
            default: align_bad_c = 1'b0;
         endcase
      end
   end

   // Accept/issue/hold FSM with registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         bus.addr       <= '0;
         bus.addr_valid <= 1'b0;
         bus.req_ready  <= 1'b1;
         bus.misaligned <= 1'b0;
         bus.bad_sel    <= 1'b0;
         bus.epc        <= '0;
         bus.exc_taken  <= 1'b0;
      end else begin
         bus.misaligned <= 1'b0;
         bus.bad_sel    <= 1'b0;
         bus.exc_taken  <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.req) begin
                  if (exc_any_c) begin
                     bus.addr       <= exc_vec_c;
                     bus.epc        <= bus.PC;
                     bus.exc_taken  <= 1'b1;
                     bus.addr_valid <= 1'b1;
                     bus.req_ready  <= 1'b0;
                     state          <= BUSY;
                  end else if (sel_bad_c) begin
                     // Reserved selector/size wins over a coincident misalignment.
                     bus.bad_sel <= 1'b1;
                  end else if (align_bad_c) begin
                     bus.misaligned <= 1'b1;
                  end else begin
                     bus.addr       <= src_c;
                     bus.addr_valid <= 1'b1;
                     bus.req_ready  <= 1'b0;
                     state          <= BUSY;
                  end
               end
            end
            BUSY: begin
               // Address held; new requests are dropped until memory acknowledges.
               if (bus.mem_ready) begin
                  bus.addr_valid <= 1'b0;
                  bus.req_ready  <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
